// File: rtl/imm_decode_stage.sv
// Immediate-generation stage between fetch and execute: decodes and sign-extends the
// RV32I immediate, computes pc+imm, and buffers up to two entries behind a valid/ready handshake.
module imm_decode_stage #(
   parameter int XLEN       = 32,
   parameter bit ZEXT_ULOAD = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      fmt_e            fmt;
   } entry_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   entry_t          dec;
   entry_t          m_q;
   entry_t          k_q;
   logic            m_valid;
   logic            k_valid;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            uload;
   logic [XLEN-1:0] imm;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign uload  = ZEXT_ULOAD && (opcode == OP_LOAD) &&
                   (funct3 == 3'b100 || funct3 == 3'b101);

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      imm = '0;
      dec = '0;
      dec.fmt = FMT_NONE;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: begin
            dec.fmt = FMT_I;
            imm = uload ? XLEN'(in_instr[31:20]) : XLEN'($signed(in_instr[31:20]));
         end
         OP_STORE: begin
            dec.fmt = FMT_S;
            imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         OP_BRANCH: begin
            dec.fmt = FMT_B;
            imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
         end
         OP_LUI, OP_AUIPC: begin
            dec.fmt = FMT_U;
            imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         OP_JAL: begin
            dec.fmt = FMT_J;
            imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
         end
         default: begin
            dec.fmt = FMT_NONE;
            imm = '0;
         end
      endcase
      dec.instr  = in_instr;
      dec.pc     = in_pc;
      dec.imm    = imm;
      dec.target = in_pc + imm;
   end

   // M is the presented entry, K the skid entry that catches one word while downstream stalls.
   // NOTE: the data registers are reset too, because the outputs must read zero out of reset;
   // sequential state is assigned with <= only so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         k_valid <= 1'b0;
         m_q     <= '0;
         k_q     <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         k_valid <= 1'b0;
      end else if (k_valid) begin
         if (out_ready) begin
            m_q     <= k_q;
            k_valid <= 1'b0;
         end
      end else if (m_valid) begin
         if (out_ready) begin
            if (in_valid) m_q <= dec;
            else          m_valid <= 1'b0;
         end else if (in_valid) begin
            k_q     <= dec;
            k_valid <= 1'b1;
         end
      end else if (in_valid) begin
         m_q     <= dec;
         m_valid <= 1'b1;
      end
   end

   assign in_ready   = !k_valid;
   assign out_valid  = m_valid;
   assign out_imm    = m_q.imm;
   assign out_fmt    = m_q.fmt;
   assign out_target = m_q.target;
   assign out_pc     = m_q.pc;
   assign out_instr  = m_q.instr;

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, parametrised immediate-generation stage between fetch and execute.
- Accepts one instruction plus PC per valid/ready handshake.
- Decodes the immediate for every RV32I format (I, S, B, U, J) and sign-extends it to XLEN. Also produces the format code and the PC-relative target.
- A 2-entry skid buffer gives full throughput under back-pressure; a flush input discards in-flight entries on branch redirect.

Parameters:
- XLEN, 32, data/PC width; legal values 32 or 64; imm, target and pc are XLEN wide.
- ZEXT_ULOAD, 0, when 1, LBU/LHU (opcode 0000011, funct3 100/101) immediates are zero-extended from 12 bits; when 0, all load immediates are sign-extended.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  synchronous discard of all held entries.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_target  out  XLEN  out_pc + out_imm, mod 2^XLEN.
- out_pc  out  XLEN  registered in_pc.
- out_instr  out  32  registered in_instr.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0 and in_ready=1.
  - out_imm, out_target, out_pc and out_instr are 0; out_fmt=NONE.
  - Skid entry is invalid.
- Decode (combinational on the incoming word; registered on accept):
  - I: opcodes 0010011, 0000011, 1100111. imm=sext(instr[31:20]). ZEXT_ULOAD rule applies to loads only.
  - S: opcode 0100011. imm=sext({instr[31:25],instr[11:7]}).
  - B: opcode 1100011. imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: opcodes 0110111, 0010111. imm=sext({instr[31:12],12'b0}), where sext matters only for XLEN=64.
  - J: opcode 1101111. imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Any other opcode: imm=0, fmt=NONE. The entry is still passed through.
  - out_target is computed at accept time and registered alongside the imm.
- Latency: 1 cycle. Data accepted at edge N appears on the outputs after edge N.
- States (main register M, skid register K):
  - EMPTY (M invalid, K invalid):
    - in_valid → FULL (load M).
  - FULL (M valid, K invalid):
    - out_ready and in_valid → FULL (reload M).
    - out_ready and not in_valid → EMPTY.
    - not out_ready and in_valid → SKID (load K). in_ready is still 1 in this cycle.
  - SKID (M valid, K valid):
    - in_ready=0.
    - out_ready → FULL, with M loaded from K.
    - Otherwise hold.
- Ordering: strictly FIFO. Entries are never dropped or duplicated except on flush.
- Output stability: while out_valid=1 and out_ready=0, every out_* signal holds its value.
- Flush:
  - Next state is EMPTY.
  - The input offered in the same cycle is discarded, even if in_valid=1.
  - in_ready=1 in the following cycle.
  - Flush has priority over every other transition.
- Reset asserted mid-operation: all entries are lost immediately, with no partial output.
- Wrap-around: out_target wraps mod 2^XLEN with no overflow flag. Example: pc=0x0000_0004, imm=-8 → target=0xFFFF_FFFC.

Test Plan:
- Format decode, XLEN=32, pc=0x100, out_ready=1:
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 (sw x1,-4(x2)) → imm 0xFFFFFFFC, fmt S.
  - 0xFE000CE3 (beq -8) → imm 0xFFFFFFF8, fmt B, target 0x000000F8.
  - 0x123452B7 (lui) → imm 0x12345000, fmt U.
  - 0x001000EF (jal +2048) → imm 0x00000800, fmt J, target 0x00000900.
- ZEXT_ULOAD=1: lbu with imm field 0xFFF → imm 0x00000FFF. Same word with ZEXT_ULOAD=0 → 0xFFFFFFFF. Unknown opcode 0x0000007F → imm 0, fmt NONE, out_valid=1.
- Back-pressure:
  - Stream instructions A,B,C,D continuously; hold out_ready=0 for 3 cycles.
  - Required: in_ready falls after B enters skid; outputs hold A stable.
  - On release, A,B,C,D are delivered in order with no gaps or duplicates.
- Flush in SKID state, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1. The flushed and offered entries never appear.
- XLEN=64, pc=0x4, beq -8 → imm 0xFFFFFFFFFFFFFFF8, target 0xFFFFFFFFFFFFFFFC.
- Assert rst_n=0 asynchronously mid-cycle while in SKID → outputs go to reset values immediately; the first instruction after release has 1-cycle latency.
